// File: rtl/mips_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// Data wins arbitration, with a starvation bound that eventually forces a fetch through.
module mips_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  logic [1:0]        r_state;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [STV_W-1:0]  r_starve_cnt;
  logic              r_sel_dm;
  logic              r_if_gnt;
  logic              r_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_dm_gnt;
  logic              r_dm_rvalid;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_any_req;
  logic w_dm_wins;

  // Arbitration: data first unless a waiting fetch has hit the starvation bound
  always_comb begin
    w_any_req = if_req | dm_req;
    if (dm_req && !(if_req && (r_starve_cnt == STV_MAX))) begin
      w_dm_wins = 1'b1;
    end else begin
      w_dm_wins = 1'b0;
    end
  end

  // Access sequencer: IDLE accepts, ACCESS holds the memory for MEM_LAT cycles, RESP returns data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lat_cnt    <= {LAT_W{1'b0}};
      r_starve_cnt <= {STV_W{1'b0}};
      r_sel_dm     <= 1'b0;
      r_if_gnt     <= 1'b0;
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= {DATA_W{1'b0}};
      r_dm_gnt     <= 1'b0;
      r_dm_rvalid  <= 1'b0;
      r_dm_rdata   <= {DATA_W{1'b0}};
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wdata  <= {DATA_W{1'b0}};
    end else begin
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state   <= ST_ACCESS;
            r_lat_cnt <= LAT_INIT;
            r_sel_dm  <= w_dm_wins;
            r_mem_en  <= 1'b1;
            if (w_dm_wins) begin
              r_mem_we    <= dm_we;
              r_mem_addr  <= dm_addr;
              r_mem_wdata <= dm_wdata;
              r_dm_gnt    <= 1'b1;
              if (if_req && (r_starve_cnt != STV_MAX)) begin
                r_starve_cnt <= r_starve_cnt + STV_W'(1);
              end
            end else begin
              r_mem_we     <= 1'b0;
              r_mem_addr   <= if_addr;
              r_if_gnt     <= 1'b1;
              r_starve_cnt <= {STV_W{1'b0}};
            end
          end
        end
        ST_ACCESS: begin
          if (r_lat_cnt == {LAT_W{1'b0}}) begin
            r_state  <= ST_RESP;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_sel_dm) begin
              r_dm_rvalid <= 1'b1;
              // Stores complete without disturbing the last load result
              if (!r_mem_we) begin
                r_dm_rdata <= mem_rdata;
              end
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= mem_rdata;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_gnt    = r_dm_gnt;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_rdata  = r_dm_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: MEM_LAT=2 main instance, MEM_LAT=1 instance for back-to-back fetches.
module tb_mips_mem_arbiter;

  typedef struct packed {
    logic        st;
    logic [31:0] d;
  } dm_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = 32'h0, dm_addr = 32'h0, dm_wdata = 32'h0, mem_rdata = 32'h0;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  logic        u1_if_req = 1'b0;
  logic [31:0] u1_if_addr = 32'h0, u1_mem_rdata = 32'h0;
  logic        u1_dm_req = 1'b0, u1_dm_we = 1'b0;
  logic [31:0] u1_dm_addr = 32'h0, u1_dm_wdata = 32'h0;
  logic        u1_if_gnt, u1_if_rvalid, u1_dm_gnt, u1_dm_rvalid, u1_mem_en, u1_mem_we, u1_busy;
  logic [31:0] u1_if_rdata, u1_dm_rdata, u1_mem_addr, u1_mem_wdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] if_q[$];
  dm_exp_t     dm_q[$];
  logic [31:0] u1_q[$];
  logic [31:0] last_dm = 32'h0;
  logic [31:0] mem[logic [31:0]];

  always #5 clk = ~clk;

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(u1_if_req), .if_addr(u1_if_addr), .if_gnt(u1_if_gnt), .if_rvalid(u1_if_rvalid),
    .if_rdata(u1_if_rdata),
    .dm_req(u1_dm_req), .dm_we(u1_dm_we), .dm_addr(u1_dm_addr), .dm_wdata(u1_dm_wdata),
    .dm_gnt(u1_dm_gnt), .dm_rvalid(u1_dm_rvalid), .dm_rdata(u1_dm_rdata),
    .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
    .mem_rdata(u1_mem_rdata), .busy(u1_busy)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: writes land on the clock edge, read data presented mid-cycle
  initial forever begin
    @(posedge clk);
    if (mem_en === 1'b1 && mem_we === 1'b1) mem[mem_addr] = mem_wdata;
  end

  initial forever begin
    @(negedge clk);
    mem_rdata    = (mem_en === 1'b1) ? rd(mem_addr) : 32'h0;
    u1_mem_rdata = (u1_mem_en === 1'b1) ? rd(u1_mem_addr) : 32'h0;
  end

  // Scoreboard monitor: pops expectations whenever a response appears
  initial forever begin
    @(negedge clk);
    if (rst) begin
      last_dm = 32'h0;
    end else begin
      if (if_gnt || dm_gnt) begin
        checks++;
        if (if_gnt && dm_gnt) begin errors++; $display("FAIL dual_gnt got=11 exp=one-hot"); end
      end
      if (if_rvalid || dm_rvalid) begin
        checks++;
        if (if_rvalid && dm_rvalid) begin errors++; $display("FAIL dual_rvalid got=11 exp=one-hot"); end
      end
      if (if_rvalid) begin
        checks++;
        if (if_q.size() == 0) begin
          errors++; $display("FAIL if_rvalid_unexpected got=1 exp=0");
        end else begin
          logic [31:0] e;
          e = if_q.pop_front();
          if (if_rdata !== e) begin errors++; $display("FAIL if_rdata got=%h exp=%h", if_rdata, e); end
        end
      end
      if (dm_rvalid) begin
        checks++;
        if (dm_q.size() == 0) begin
          errors++; $display("FAIL dm_rvalid_unexpected got=1 exp=0");
        end else begin
          dm_exp_t     de;
          logic [31:0] e;
          de = dm_q.pop_front();
          e  = de.st ? last_dm : de.d;
          if (dm_rdata !== e) begin errors++; $display("FAIL dm_rdata got=%h exp=%h", dm_rdata, e); end
          last_dm = e;
        end
      end
      if (u1_if_rvalid) begin
        checks++;
        if (u1_q.size() == 0) begin
          errors++; $display("FAIL u1_rvalid_unexpected got=1 exp=0");
        end else begin
          logic [31:0] e;
          e = u1_q.pop_front();
          if (u1_if_rdata !== e) begin errors++; $display("FAIL u1_if_rdata got=%h exp=%h", u1_if_rdata, e); end
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin checks++; errors++; $display("FAIL %s_timeout got=busy exp=idle", name); end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy} !== 7'b0) begin
      errors++;
      $display("FAIL %s_ctrl got=%b exp=%b", name, {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy}, 7'b0);
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL %s_data got=%h/%h/%h/%h exp=0", name, mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    checks++;
    if ({u1_if_gnt, u1_if_rvalid, u1_mem_en, u1_busy, u1_if_rdata} !== 36'h0) begin
      errors++; $display("FAIL reset_u1 got=%b exp=0", {u1_if_gnt, u1_if_rvalid, u1_mem_en, u1_busy});
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_fetch();
    mem[32'h40] = 32'h8C010004;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40; if_q.push_back(32'h8C010004);
    @(negedge clk);
    checks++;
    if ({if_gnt, dm_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 32'h40) begin
      errors++; $display("FAIL fetch_c1 got=%b addr=%h exp=1010 addr=00000040", {if_gnt, dm_gnt, mem_en, mem_we}, mem_addr);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_gnt, mem_en, if_rvalid} !== 3'b010) begin
      errors++; $display("FAIL fetch_c2 got=%b exp=010", {if_gnt, mem_en, if_rvalid});
    end
    @(negedge clk);
    checks++;
    if ({if_rvalid, mem_en} !== 2'b10 || if_rdata !== 32'h8C010004) begin
      errors++; $display("FAIL fetch_c3 got=%b data=%h exp=10 data=8c010004", {if_rvalid, mem_en}, if_rdata);
    end
    @(negedge clk);
    checks++;
    if ({busy, if_rvalid} !== 2'b00) begin errors++; $display("FAIL fetch_idle got=%b exp=00", {busy, if_rvalid}); end
  endtask

  task automatic test_priority();
    mem[32'h100] = 32'h12345678;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h80; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    dm_q.push_back('{st: 1'b0, d: 32'h12345678});
    if_q.push_back(rd(32'h80));
    @(negedge clk);
    checks++;
    if ({dm_gnt, if_gnt} !== 2'b10) begin errors++; $display("FAIL prio_gnt got=%b exp=10", {dm_gnt, if_gnt}); end
    dm_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({dm_rvalid, if_gnt} !== 2'b10) begin errors++; $display("FAIL prio_dm_resp got=%b exp=10", {dm_rvalid, if_gnt}); end
    @(negedge clk);
    checks++;
    if ({busy, if_gnt} !== 2'b00) begin errors++; $display("FAIL prio_idle got=%b exp=00", {busy, if_gnt}); end
    @(negedge clk);
    checks++;
    if ({if_gnt, dm_gnt} !== 2'b10) begin errors++; $display("FAIL prio_if_gnt got=%b exp=10", {if_gnt, dm_gnt}); end
    if_req = 1'b0;
    wait_idle("prio");
  endtask

  task automatic test_starvation();
    int seq[$];
    int exp_seq[6] = '{1, 1, 1, 1, 0, 1};
    int n = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h84; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h104;
    while (seq.size() < 6 && n < 100) begin
      @(negedge clk); n++;
      if (dm_gnt) begin seq.push_back(1); dm_q.push_back('{st: 1'b0, d: rd(32'h104)}); end
      if (if_gnt) begin seq.push_back(0); if_q.push_back(rd(32'h84)); if_req = 1'b0; end
    end
    dm_req = 1'b0;
    checks++;
    if (seq.size() != 6) begin
      errors++; $display("FAIL starve_timeout got=%0d grants exp=6", seq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (seq[i] != exp_seq[i]) begin
          errors++; $display("FAIL starve_order idx=%0d got=%0d exp=%0d (1=dm)", i, seq[i], exp_seq[i]);
        end
      end
    end
    wait_idle("starve");
  endtask

  task automatic test_store();
    @(negedge clk);
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    dm_q.push_back('{st: 1'b1, d: 32'h0});
    @(negedge clk);
    checks++;
    if (dm_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt got=%b exp=1", dm_gnt); end
    dm_req = 1'b0; dm_wdata = 32'h0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEADBEEF) begin
        errors++; $display("FAIL store_access c=%0d got=%b %h %h exp=11 00000200 deadbeef", c, {mem_en, mem_we}, mem_addr, mem_wdata);
      end
      @(negedge clk);
    end
    checks++;
    if ({dm_rvalid, mem_we} !== 2'b10 || dm_rdata !== 32'h0104FEFB) begin
      errors++; $display("FAIL store_resp got=%b rdata=%h exp=10 rdata=0104fefb", {dm_rvalid, mem_we}, dm_rdata);
    end
    wait_idle("store");
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    dm_q.push_back('{st: 1'b0, d: 32'hDEADBEEF});
    @(negedge clk);
    checks++;
    if (dm_gnt !== 1'b1) begin errors++; $display("FAIL load_after_store_gnt got=%b exp=1", dm_gnt); end
    dm_req = 1'b0;
    wait_idle("load_after_store");
  endtask

  task automatic test_reset_abort();
    int rv = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h44; if_q.push_back(rd(32'h44));
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL abort_gnt got=%b exp=1", if_gnt); end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b1) begin errors++; $display("FAIL abort_access2 got=%b exp=1", mem_en); end
    #1 rst = 1'b1;
    if_q.delete();
    #1 check_all_zero("abort");
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (4) begin @(negedge clk); if (if_rvalid || dm_rvalid) rv++; end
    checks++;
    if (rv != 0) begin errors++; $display("FAIL abort_no_rvalid got=%0d exp=0", rv); end
    if_req = 1'b1; if_addr = 32'h48; if_q.push_back(rd(32'h48));
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL post_reset_gnt got=%b exp=1", if_gnt); end
    if_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (if_rvalid !== 1'b1) begin errors++; $display("FAIL post_reset_rvalid got=%b exp=1", if_rvalid); end
    wait_idle("post_reset");
  endtask

  task automatic test_back_to_back();
    int g = 0, r = 0, last_g = -100, cyc = 0;
    @(negedge clk);
    u1_if_req = 1'b1; u1_if_addr = 32'h60;
    while ((g < 3 || u1_busy) && cyc < 60) begin
      @(negedge clk); cyc++;
      if (u1_if_gnt) begin
        if (g > 0) begin
          checks++;
          if (cyc - last_g != 3) begin errors++; $display("FAIL b2b_interval got=%0d exp=3", cyc - last_g); end
        end
        g++; last_g = cyc; u1_q.push_back(rd(32'h60));
        if (g == 3) u1_if_req = 1'b0;
      end
      if (u1_if_rvalid) begin
        r++;
        checks++;
        if (cyc - last_g != 1) begin errors++; $display("FAIL b2b_rvalid_lat got=%0d exp=1", cyc - last_g); end
      end
    end
    checks++;
    if (g != 3 || r != 3) begin errors++; $display("FAIL b2b_counts got=%0d/%0d exp=3/3", g, r); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_starvation();
    test_store();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (if_q.size() + dm_q.size() + u1_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got=%0d pending exp=0", if_q.size() + dm_q.size() + u1_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
